// File: rtl/pkt_merge_avlstrm_if.sv
// rtl/pkt_merge_avlstrm_if.sv - Avalon-ST packet stream bundle (data/valid/sop/eop/empty/ready)
interface pkt_merge_avlstrm_if #(
   parameter int DWIDTH = 512,
   parameter int EWIDTH = 6
);
   logic [DWIDTH-1:0] data;
   logic              valid;
   logic              sop;
   logic              eop;
   logic [EWIDTH-1:0] empty;
   logic              ready;

   modport master (output data, valid, sop, eop, empty, input ready);
   modport slave  (input data, valid, sop, eop, empty, output ready);
endinterface

// File: rtl/pkt_merge_avlstrm.sv
// rtl/pkt_merge_avlstrm.sv - packet-atomic round-robin 2:1 Avalon-ST merge with registered output
// Optional framing checker and stats_proto_err_o port: define PKT_MERGE_PROTO_CHK_EN.
module pkt_merge_avlstrm #(
   parameter int DWIDTH = 512,
   parameter int EWIDTH = 6
) (
   input  logic                clk_i,
   input  logic                rst_i,
   pkt_merge_avlstrm_if.slave  in0_i,
   pkt_merge_avlstrm_if.slave  in1_i,
   pkt_merge_avlstrm_if.master out_o,
   output logic [31:0]         stats_in0_pkt_o,
   output logic [31:0]         stats_in1_pkt_o,
   output logic [31:0]         stats_out_pkt_o
`ifdef PKT_MERGE_PROTO_CHK_EN
   ,
   output logic [31:0]         stats_proto_err_o
`endif
);
   typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

   state_t            state_q, state_d;
   logic              rr_q, rr_d;
   logic              out_valid_q, out_sop_q, out_eop_q;
   logic [DWIDTH-1:0] out_data_q;
   logic [EWIDTH-1:0] out_empty_q;
   logic [31:0]       in0_pkt_q, in1_pkt_q, out_pkt_q;

   logic              load, grant1, acc, fwd, idle;
   logic              sel_valid, sel_sop, sel_eop;
   logic [DWIDTH-1:0] sel_data;
   logic [EWIDTH-1:0] sel_empty;

   assign load = !out_valid_q | out_o.ready;
   assign idle = (state_q == IDLE);

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      grant1  = 1'b0;
      case (state_q)
         IDLE:    grant1 = in1_i.valid & (rr_q | !in0_i.valid);
         LOCK1:   grant1 = 1'b1;
         default: grant1 = 1'b0;
      endcase
      sel_valid = grant1 ? in1_i.valid : in0_i.valid;
      sel_sop   = grant1 ? in1_i.sop   : in0_i.sop;
      sel_eop   = grant1 ? in1_i.eop   : in0_i.eop;
      sel_data  = grant1 ? in1_i.data  : in0_i.data;
      sel_empty = grant1 ? in1_i.empty : in0_i.empty;
      acc       = load & sel_valid;
      // A sop seen while locked re-opens the lock on the same source, so only eop releases it.
      if (acc) begin
         if (idle) begin
            if (sel_sop & !sel_eop) begin
               state_d = grant1 ? LOCK1 : LOCK0;
            end else if (sel_sop) begin
               rr_d = !grant1;
            end
         end else if (sel_eop) begin
            state_d = IDLE;
            rr_d    = !grant1;
         end
      end
   end

   assign in0_i.ready = !grant1 & load;
   assign in1_i.ready = grant1 & load;

`ifdef PKT_MERGE_PROTO_CHK_EN
   logic        proto_err;
   logic [31:0] proto_err_q;

   assign proto_err = acc & (idle ? !sel_sop : sel_sop);
   assign fwd       = acc & !(idle & !sel_sop);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         proto_err_q <= '0;
      end else if (proto_err) begin
         proto_err_q <= proto_err_q + 32'd1;
      end
   end

   assign stats_proto_err_o = proto_err_q;
`else
   assign fwd = acc;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         rr_q        <= 1'b0;
         out_valid_q <= 1'b0;
         out_sop_q   <= 1'b0;
         out_eop_q   <= 1'b0;
         out_data_q  <= '0;
         out_empty_q <= '0;
         in0_pkt_q   <= '0;
         in1_pkt_q   <= '0;
         out_pkt_q   <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         if (load) begin
            out_valid_q <= fwd;
            if (fwd) begin
               out_sop_q   <= sel_sop;
               out_eop_q   <= sel_eop;
               out_data_q  <= sel_data;
               out_empty_q <= sel_empty;
            end
         end
         if (acc & sel_eop & !grant1) in0_pkt_q <= in0_pkt_q + 32'd1;
         if (acc & sel_eop & grant1)  in1_pkt_q <= in1_pkt_q + 32'd1;
         if (out_valid_q & out_o.ready & out_eop_q) out_pkt_q <= out_pkt_q + 32'd1;
      end
   end

   assign out_o.valid     = out_valid_q;
   assign out_o.sop       = out_sop_q;
   assign out_o.eop       = out_eop_q;
   assign out_o.data      = out_data_q;
   assign out_o.empty     = out_empty_q;
   assign stats_in0_pkt_o = in0_pkt_q;
   assign stats_in1_pkt_o = in1_pkt_q;
   assign stats_out_pkt_o = out_pkt_q;
endmodule

// File: tb/tb_pkt_merge_avlstrm.sv
// tb/tb_pkt_merge_avlstrm.sv - self-checking bench for pkt_merge_avlstrm (vector table + randomized packet scoreboard)
`timescale 1ns/1ps
module tb_pkt_merge_avlstrm;
   localparam int DW  = 512;
   localparam int EW  = 6;
   localparam int NPK = 40;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   pkt_merge_avlstrm_if #(.DWIDTH(DW), .EWIDTH(EW)) in0 ();
   pkt_merge_avlstrm_if #(.DWIDTH(DW), .EWIDTH(EW)) in1 ();
   pkt_merge_avlstrm_if #(.DWIDTH(DW), .EWIDTH(EW)) out ();
   logic [31:0] st0, st1, sto;
`ifdef PKT_MERGE_PROTO_CHK_EN
   logic [31:0] sterr;
`endif

   pkt_merge_avlstrm #(.DWIDTH(DW), .EWIDTH(EW)) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .in0_i           (in0),
      .in1_i           (in1),
      .out_o           (out),
      .stats_in0_pkt_o (st0),
      .stats_in1_pkt_o (st1),
      .stats_out_pkt_o (sto)
`ifdef PKT_MERGE_PROTO_CHK_EN
      , .stats_proto_err_o (sterr)
`endif
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic note_fail(input string name, input string what);
      n_chk++;
      n_fail++;
      $display("FAIL %s: got %s required nothing of the kind", name, what);
   endtask

   task automatic drive(input int p, input logic v, input logic s, input logic e,
                        input logic [DW-1:0] d, input logic [EW-1:0] m);
      if (p == 0) begin
         in0.valid = v; in0.sop = s; in0.eop = e; in0.data = d; in0.empty = m;
      end else begin
         in1.valid = v; in1.sop = s; in1.eop = e; in1.data = d; in1.empty = m;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      drive(0, 0, 0, 0, '0, '0);
      drive(1, 0, 0, 0, '0, '0);
      out.ready = 1'b1;
      rst = 1'b1;
      #2;
      check("rst_out_valid", out.valid, 0);
      check("rst_out_sop", out.sop, 0);
      check("rst_out_eop", out.eop, 0);
      check("rst_out_data", out.data, 0);
      check("rst_out_empty", out.empty, 0);
      check("rst_stats_in0", st0, 0);
      check("rst_stats_in1", st1, 0);
      check("rst_stats_out", sto, 0);
`ifdef PKT_MERGE_PROTO_CHK_EN
      check("rst_stats_err", sterr, 0);
`endif
      @(negedge clk);
      rst = 1'b0;
   endtask

   typedef struct {
      bit rs;
      bit v0, s0, e0; logic [7:0] d0;
      bit v1, s1, e1; logic [7:0] d1;
      bit ordy;
      bit r0, r1, ov, os, oe; logic [7:0] od;
      int x0, x1, xo;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input bit rs, input bit v0, input bit s0, input bit e0, input logic [7:0] d0,
                      input bit v1, input bit s1, input bit e1, input logic [7:0] d1, input bit ordy,
                      input bit r0, input bit r1, input bit ov, input bit os, input bit oe,
                      input logic [7:0] od, input int x0, input int x1, input int xo);
      vec_t v;
      v.rs = rs; v.v0 = v0; v.s0 = s0; v.e0 = e0; v.d0 = d0;
      v.v1 = v1; v.s1 = s1; v.e1 = e1; v.d1 = d1; v.ordy = ordy;
      v.r0 = r0; v.r1 = r1; v.ov = ov; v.os = os; v.oe = oe; v.od = od;
      v.x0 = x0; v.x1 = x1; v.xo = xo;
      tbl.push_back(v);
   endtask

   typedef struct {
      logic [DW-1:0] d;
      logic          s, e;
      logic [EW-1:0] m;
   } beat_t;
   beat_t dq0[$], dq1[$], eq0[$], eq1[$];

   initial begin
      beat_t b, ob, prev;
      logic [DW-1:0] w;
      bit pend0, pend1, stall_prev;
      int cur_src, cyc, len;

      // in0 data 0x0n carries empty 5 on eop, in1 data 0x1n carries empty 3
      // single 3-beat packet from in0
      add(1, 1,1,0,8'h01, 0,0,0,8'h00, 1, 1,0, 0,0,0,8'h00, 0,0,0);
      add(0, 1,0,0,8'h02, 0,0,0,8'h00, 1, 1,0, 1,1,0,8'h01, 0,0,0);
      add(0, 1,0,1,8'h03, 0,0,0,8'h00, 1, 1,0, 1,0,0,8'h02, 0,0,0);
      add(0, 0,0,0,8'h00, 0,0,0,8'h00, 1, 1,0, 1,0,1,8'h03, 1,0,0);
      add(0, 0,0,0,8'h00, 0,0,0,8'h00, 1, 1,0, 0,0,0,8'h00, 1,0,1);
      // both sources streaming 2-beat packets: in0,in1,in0,in1
      add(1, 1,1,0,8'h01, 1,1,0,8'h11, 1, 1,0, 0,0,0,8'h00, 0,0,0);
      add(0, 1,0,1,8'h02, 1,1,0,8'h11, 1, 1,0, 1,1,0,8'h01, 0,0,0);
      add(0, 1,1,0,8'h03, 1,1,0,8'h11, 1, 0,1, 1,0,1,8'h02, 1,0,0);
      add(0, 1,1,0,8'h03, 1,0,1,8'h12, 1, 0,1, 1,1,0,8'h11, 1,0,1);
      add(0, 1,1,0,8'h03, 1,1,0,8'h13, 1, 1,0, 1,0,1,8'h12, 1,1,1);
      add(0, 1,0,1,8'h04, 1,1,0,8'h13, 1, 1,0, 1,1,0,8'h03, 1,1,2);
      add(0, 0,0,0,8'h00, 1,1,0,8'h13, 1, 0,1, 1,0,1,8'h04, 2,1,2);
      add(0, 0,0,0,8'h00, 1,0,1,8'h14, 1, 0,1, 1,1,0,8'h13, 2,1,3);
      add(0, 0,0,0,8'h00, 0,0,0,8'h00, 1, 1,0, 1,0,1,8'h14, 2,2,3);
      add(0, 0,0,0,8'h00, 0,0,0,8'h00, 1, 1,0, 0,0,0,8'h00, 2,2,4);
      // in1 single-beat packet waits for the in0 lock to release
      add(1, 1,1,0,8'h01, 0,0,0,8'h00, 1, 1,0, 0,0,0,8'h00, 0,0,0);
      add(0, 1,0,0,8'h02, 1,1,1,8'h11, 1, 1,0, 1,1,0,8'h01, 0,0,0);
      add(0, 1,0,0,8'h03, 1,1,1,8'h11, 1, 1,0, 1,0,0,8'h02, 0,0,0);
      add(0, 1,0,1,8'h04, 1,1,1,8'h11, 1, 1,0, 1,0,0,8'h03, 0,0,0);
      add(0, 0,0,0,8'h00, 1,1,1,8'h11, 1, 0,1, 1,0,1,8'h04, 1,0,0);
      add(0, 0,0,0,8'h00, 0,0,0,8'h00, 1, 1,0, 1,1,1,8'h11, 1,1,1);
      add(0, 0,0,0,8'h00, 0,0,0,8'h00, 1, 1,0, 0,0,0,8'h00, 1,1,2);
      // out_ready 1,0,0,1 stall
      add(1, 1,1,0,8'h01, 0,0,0,8'h00, 1, 1,0, 0,0,0,8'h00, 0,0,0);
      add(0, 1,0,0,8'h02, 0,0,0,8'h00, 0, 0,0, 1,1,0,8'h01, 0,0,0);
      add(0, 1,0,0,8'h02, 0,0,0,8'h00, 0, 0,0, 1,1,0,8'h01, 0,0,0);
      add(0, 1,0,0,8'h02, 0,0,0,8'h00, 1, 1,0, 1,1,0,8'h01, 0,0,0);
      add(0, 1,0,1,8'h03, 0,0,0,8'h00, 1, 1,0, 1,0,0,8'h02, 0,0,0);
      add(0, 0,0,0,8'h00, 0,0,0,8'h00, 1, 1,0, 1,0,1,8'h03, 1,0,0);
      add(0, 0,0,0,8'h00, 0,0,0,8'h00, 1, 1,0, 0,0,0,8'h00, 1,0,1);

      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].rs) do_reset();
         @(negedge clk);
         drive(0, tbl[i].v0, tbl[i].s0, tbl[i].e0, {{(DW-8){1'b0}}, tbl[i].d0}, tbl[i].e0 ? 6'd5 : 6'd0);
         drive(1, tbl[i].v1, tbl[i].s1, tbl[i].e1, {{(DW-8){1'b0}}, tbl[i].d1}, tbl[i].e1 ? 6'd3 : 6'd0);
         out.ready = tbl[i].ordy;
         #2;
         check($sformatf("vec%0d_in0_ready", i), in0.ready, tbl[i].r0);
         check($sformatf("vec%0d_in1_ready", i), in1.ready, tbl[i].r1);
         check($sformatf("vec%0d_out_valid", i), out.valid, tbl[i].ov);
         if (tbl[i].ov) begin
            check($sformatf("vec%0d_out_data", i), out.data, {{(DW-8){1'b0}}, tbl[i].od});
            check($sformatf("vec%0d_out_sop", i), out.sop, tbl[i].os);
            check($sformatf("vec%0d_out_eop", i), out.eop, tbl[i].oe);
            if (tbl[i].oe)
               check($sformatf("vec%0d_out_empty", i), out.empty, tbl[i].od[4] ? 6'd3 : 6'd5);
         end
         check($sformatf("vec%0d_stats_in0", i), st0, tbl[i].x0);
         check($sformatf("vec%0d_stats_in1", i), st1, tbl[i].x1);
         check($sformatf("vec%0d_stats_out", i), sto, tbl[i].xo);
      end

      // reset mid-packet from in1 after a completed in0 packet moved rr to in1
      do_reset();
      @(negedge clk);
      drive(0, 1, 1, 1, 512'h01, 6'd5);
      @(negedge clk);
      drive(0, 0, 0, 0, '0, '0);
      drive(1, 1, 1, 0, 512'h11, 6'd0);
      #2 check("mid_in1_granted", in1.ready, 1);
      @(negedge clk);
      drive(1, 1, 0, 0, 512'h12, 6'd0);
      #2 check("mid_pre_stats_in0", st0, 1);
      check("mid_pre_stats_out", sto, 1);
      @(negedge clk);
      drive(1, 1, 0, 0, 512'h13, 6'd0);
      rst = 1'b1;
      #2 check("mid_rst_out_valid", out.valid, 0);
      check("mid_rst_out_data", out.data, 0);
      check("mid_rst_stats_in0", st0, 0);
      check("mid_rst_stats_out", sto, 0);
      @(negedge clk);
      rst = 1'b0;
      drive(0, 1, 1, 1, 512'h02, 6'd5);
      drive(1, 1, 1, 1, 512'h14, 6'd3);
      #2 check("post_rst_in0_first", in0.ready, 1);
      check("post_rst_in1_wait", in1.ready, 0);
      @(negedge clk);
      #2 check("post_rst_out_data", out.data, 512'h02);
      check("post_rst_out_valid", out.valid, 1);

`ifdef PKT_MERGE_PROTO_CHK_EN
      do_reset();
      @(negedge clk);
      drive(0, 1, 0, 0, 512'h05, 6'd0);
      #2 check("proto_idle_nonsop_ready", in0.ready, 1);
      @(negedge clk);
      drive(0, 1, 1, 0, 512'h01, 6'd0);
      #2 check("proto_drop_out_valid", out.valid, 0);
      check("proto_err_first", sterr, 1);
      @(negedge clk);
      drive(0, 1, 1, 0, 512'h02, 6'd0);
      #2 check("proto_lock_out_data", out.data, 512'h01);
      @(negedge clk);
      drive(0, 0, 0, 0, '0, '0);
      #2 check("proto_sop_fwd_data", out.data, 512'h02);
      check("proto_sop_fwd_sop", out.sop, 1);
      check("proto_sop_fwd_valid", out.valid, 1);
      check("proto_err_second", sterr, 2);
`endif

      // randomized packets from both sources, random gaps and backpressure
      do_reset();
      for (int p = 0; p < 2; p++) begin
         for (int k = 0; k < NPK; k++) begin
            len = $urandom_range(1, 4);
            for (int j = 0; j < len; j++) begin
               for (int q = 0; q < DW / 32; q++) w[q*32 +: 32] = $urandom;
               w[DW-1] = p[0];
               b.d = w;
               b.s = (j == 0);
               b.e = (j == len - 1);
               b.m = b.e ? EW'($urandom_range(0, 63)) : '0;
               if (p == 0) begin dq0.push_back(b); eq0.push_back(b); end
               else        begin dq1.push_back(b); eq1.push_back(b); end
            end
         end
      end
      pend0 = 0; pend1 = 0; stall_prev = 0; cur_src = -1; cyc = 0;
      prev.d = '0; prev.s = 0; prev.e = 0; prev.m = '0;
      while ((eq0.size() + eq1.size() != 0) && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         if (!pend0 && dq0.size() > 0 && $urandom_range(0, 3) != 0) begin
            b = dq0.pop_front(); drive(0, 1, b.s, b.e, b.d, b.m); pend0 = 1;
         end else if (!pend0) drive(0, 0, 0, 0, '0, '0);
         if (!pend1 && dq1.size() > 0 && $urandom_range(0, 3) != 0) begin
            b = dq1.pop_front(); drive(1, 1, b.s, b.e, b.d, b.m); pend1 = 1;
         end else if (!pend1) drive(1, 0, 0, 0, '0, '0);
         out.ready = ($urandom_range(0, 3) != 0);
         #2;
         ob.d = out.data; ob.s = out.sop; ob.e = out.eop; ob.m = out.empty;
         if (stall_prev) begin
            check("rnd_stall_valid", out.valid, 1);
            check("rnd_stall_data", ob.d, prev.d);
            check("rnd_stall_flags", {ob.s, ob.e, ob.m}, {prev.s, prev.e, prev.m});
         end
         if (out.valid && !out.ready)
            check("rnd_stall_inready", {in0.ready, in1.ready}, 2'b00);
         if (out.valid && out.ready) begin
            if (ob.s) cur_src = int'(ob.d[DW-1]);
            if (cur_src < 0) note_fail("rnd_first_sop", "beat before any sop");
            else begin
               check("rnd_no_interleave", ob.d[DW-1], cur_src[0]);
               if (cur_src == 0 && eq0.size() > 0) b = eq0.pop_front();
               else if (cur_src == 1 && eq1.size() > 0) b = eq1.pop_front();
               else begin
                  note_fail("rnd_extra_beat", "unexpected output beat");
                  b = ob;
               end
               check("rnd_beat_data", ob.d, b.d);
               check("rnd_beat_flags", {ob.s, ob.e, ob.m}, {b.s, b.e, b.m});
            end
         end
         stall_prev = out.valid && !out.ready;
         prev = ob;
         if (pend0 && in0.ready) pend0 = 0;
         if (pend1 && in1.ready) pend1 = 0;
      end
      if (cyc >= 4000) note_fail("rnd_timeout", "cycle budget exhausted");
      @(negedge clk);
      drive(0, 0, 0, 0, '0, '0);
      drive(1, 0, 0, 0, '0, '0);
      #2 check("rnd_stats_in0", st0, NPK);
      check("rnd_stats_in1", st1, NPK);
      check("rnd_stats_out", sto, 2 * NPK);
      check("rnd_drained", out.valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/pkt_merge_avlstrm.md
Name: pkt_merge_avlstrm

Overview:
Packet-atomic 2:1 merge for 512-bit Avalon-ST packet streams. It is the join counterpart to the port-group fork: it recombines the no-check path (in0) and the checked path (in1) into one ordered-per-source stream toward the egress/DMA side. Arbitration is round-robin at packet boundaries, and the output is registered.

Parameters:
DWIDTH, 512, data width of all streams
EWIDTH, 6, width of empty field (log2(DWIDTH/8))

Ports:
Clk  input  1  clock
Rst  input  1  asynchronous, active-high reset
in0_data  input  DWIDTH  no-check stream data
in0_valid  input  1  beat valid
in0_sop  input  1  start of packet
in0_eop  input  1  end of packet
in0_empty  input  EWIDTH  empty bytes on eop beat
in0_ready  output  1  accept (ready latency 0)
in1_data/in1_valid/in1_sop/in1_eop/in1_empty/in1_ready  same as in0, for the checked stream
out_data  output  DWIDTH  merged data
out_valid  output  1  beat valid
out_sop  output  1  start of packet
out_eop  output  1  end of packet
out_empty  output  EWIDTH  empty bytes
out_ready  input  1  downstream accept (ready latency 0)
stats_in0_pkt  output  32  eop beats accepted on in0
stats_in1_pkt  output  32  eop beats accepted on in1
stats_out_pkt  output  32  eop beats transferred on out

Behaviour:
- Transfer on any port = valid & ready in the same cycle. Ready latency is 0.
- Output register stage: `load = !out_valid | out_ready`. `inX_ready = grantX & load` (combinational).
- Latency: an input beat accepted at cycle t appears on out_* at t+1.
- FSM states:
  - IDLE: grant = in1 if `rr==1` and in1_valid, else in0 if in0_valid, else in1 if in1_valid.
  - LOCK0 / LOCK1: grant is fixed to that input.
- IDLE -> LOCKx: on an accepted sop beat from x without eop.
- Single-beat packet (sop & eop) in IDLE: stays in IDLE. rr toggles to the other input. The next packet can be arbitrated the very next cycle with no bubble.
- LOCKx -> IDLE: on an accepted eop beat from x. rr becomes !x.
- While in LOCKx, the other input's ready = 0 regardless of its valid.
- rr resets to 0, so in0 is favoured first after reset.
- Back-to-back packets from a lone active source: no idle cycle inserted.
- Output holds data/sop/eop/empty stable while `out_valid & !out_ready`.
- Reset (any time, including mid-packet): out_valid = 0, out_sop = out_eop = 0, out_data = 0, out_empty = 0, state = IDLE, rr = 0, all stats = 0. A partially forwarded packet is dropped. The sources must also reset.
- Stats: +1 per accepted eop beat; 32-bit wrap (0xFFFFFFFF -> 0). stats_out_pkt increments on out_valid & out_ready & out_eop.
- Beat arriving in IDLE without sop: forwarded as-is, no lock taken; the next arbitration happens the next cycle.

Optional Feature:
PKT_MERGE_PROTO_CHK_EN
- Defined:
  - Adds output stats_proto_err (32): +1 for each accepted beat that is a sop while in LOCKx, or a non-sop beat while in IDLE.
  - Offending non-sop beats in IDLE are discarded (ready asserted, not forwarded).
  - A sop in LOCKx forces an implicit packet close: the beat is forwarded, and the FSM restarts lock on the new packet.
- Undefined: port absent. Behaviour is exactly as in Behaviour; there is no checking.

Test Plan:
- Reset, then in0 sends a 3-beat packet (data 0x1,0x2,0x3, empty=5 on eop), out_ready=1 -> out shows 0x1(sop),0x2,0x3(eop, empty=5) at cycles t+1..t+3. stats_in0_pkt = stats_out_pkt = 1.
- in0 and in1 both present 2-beat packets continuously for 4 packets -> output order is in0,in1,in0,in1 with no interleaving within a packet. stats_in0_pkt = stats_in1_pkt = 2, stats_out_pkt = 4.
- in0 sends a 4-beat packet; at beat 2, in1 raises valid with a single-beat packet -> in1_ready stays 0 until in0 eop is accepted. The in1 packet is emitted on the cycle right after in0's eop appears on out.
- Toggle out_ready 1,0,0,1 during a transfer -> out_* stay stable while stalled, no beat is lost or duplicated, and inX_ready = 0 while out_valid & !out_ready.
- Assert Rst for 1 cycle mid-packet (after beat 2 of 4 from in1) -> out_valid = 0, all stats = 0. The next sop from in0 is granted first (rr = 0).
- With PKT_MERGE_PROTO_CHK_EN: send a non-sop beat in IDLE, then a sop inside a locked packet -> stats_proto_err = 2, the first beat does not appear on out, and the second beat is forwarded with sop = 1.
